ahb3_arbiter: RTL and testbench

- Multi-master AHB3-Lite arbiter; sits directly upstream of the slave address decoder and drives its single master-side port.
- Multiplexes MASTERS independent AHB-Lite master ports (CPU instruction/data, DMA, debug) onto one bus.
- Uses round-robin grant with burst and lock protection.
- Tracks address-phase and data-phase ownership separately so responses and write data are routed to the correct master.

---
 rtl/ahb3_arbiter_if.sv | 53 +++++
 rtl/ahb3_arbiter.sv | 138 +++++++++++++
 tb/tb_ahb3_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3_arbiter_if.sv
// Bundles the per-master AHB-Lite ports and the shared decoder-side bus of
// the arbiter; the slave modport is the arbiter's view, master is the environment's.
interface ahb3_arbiter_if #(
    parameter int MASTERS = 2,
    parameter int XLEN    = 32,
    parameter int PLEN    = 32
);
    localparam int SW = XLEN >> 3;

    logic [MASTERS-1:0]           m_hsel_i;
    logic [MASTERS-1:0][PLEN-1:0] m_haddr_i;
    logic [MASTERS-1:0][XLEN-1:0] m_hwdata_i;
    logic [MASTERS-1:0]           m_hwrite_i;
    logic [MASTERS-1:0][2:0]      m_hsize_i;
    logic [MASTERS-1:0][2:0]      m_hburst_i;
    logic [MASTERS-1:0][SW-1:0]   m_hprot_i;
    logic [MASTERS-1:0][1:0]      m_htrans_i;
    logic [MASTERS-1:0]           m_hmastlock_i;
    logic [MASTERS-1:0][XLEN-1:0] m_hrdata_o;
    logic [MASTERS-1:0]           m_hready_o;
    logic [MASTERS-1:0]           m_hresp_o;

    logic                         bus_hsel_o;
    logic [PLEN-1:0]              bus_haddr_o;
    logic [XLEN-1:0]              bus_hwdata_o;
    logic                         bus_hwrite_o;
    logic [2:0]                   bus_hsize_o;
    logic [2:0]                   bus_hburst_o;
    logic [SW-1:0]                bus_hprot_o;
    logic [1:0]                   bus_htrans_o;
    logic                         bus_hmastlock_o;
    logic [XLEN-1:0]              bus_hrdata_i;
    logic                         bus_hready_i;
    logic                         bus_hresp_i;

    modport slave (
        input  m_hsel_i, m_haddr_i, m_hwdata_i, m_hwrite_i, m_hsize_i,
               m_hburst_i, m_hprot_i, m_htrans_i, m_hmastlock_i,
               bus_hrdata_i, bus_hready_i, bus_hresp_i,
        output m_hrdata_o, m_hready_o, m_hresp_o,
               bus_hsel_o, bus_haddr_o, bus_hwdata_o, bus_hwrite_o, bus_hsize_o,
               bus_hburst_o, bus_hprot_o, bus_htrans_o, bus_hmastlock_o
    );

    modport master (
        output m_hsel_i, m_haddr_i, m_hwdata_i, m_hwrite_i, m_hsize_i,
               m_hburst_i, m_hprot_i, m_htrans_i, m_hmastlock_i,
               bus_hrdata_i, bus_hready_i, bus_hresp_i,
        input  m_hrdata_o, m_hready_o, m_hresp_o,
               bus_hsel_o, bus_haddr_o, bus_hwdata_o, bus_hwrite_o, bus_hsize_o,
               bus_hburst_o, bus_hprot_o, bus_htrans_o, bus_hmastlock_o
    );
endinterface

// File: rtl/ahb3_arbiter.sv
// Round-robin AHB3-Lite arbiter with burst/lock protection; address-phase and
// data-phase ownership are tracked separately to steer hwdata and responses.
module ahb3_arbiter #(
    parameter int MASTERS = 2,
    parameter int XLEN    = 32,
    parameter int PLEN    = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    ahb3_arbiter_if.slave bus_if
);
    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    typedef logic [IW-1:0] idx_t;

    logic [MASTERS-1:0] req;
    idx_t               owner;
    idx_t               last;
    idx_t               downer;
    logic               dvalid;
    logic [4:0]         beat_cnt;
    logic               hold;
    logic               found;
    idx_t               winner;
    idx_t               cand;
    logic [4:0]         beat_load;

    always_comb begin
        req = '0;
        for (int i = 0; i < MASTERS; i++) begin
            req[i] = bus_if.m_hsel_i[i] & bus_if.m_htrans_i[i][1];
        end
    end

    // Address/control follow the address-phase owner; an unselected owner parks the bus IDLE.
    always_comb begin
        bus_if.bus_hsel_o   = bus_if.m_hsel_i[owner];
        bus_if.bus_haddr_o  = bus_if.m_haddr_i[owner];
        bus_if.bus_hwrite_o = bus_if.m_hwrite_i[owner];
        bus_if.bus_hsize_o  = bus_if.m_hsize_i[owner];
        bus_if.bus_hburst_o = bus_if.m_hburst_i[owner];
        bus_if.bus_hprot_o  = bus_if.m_hprot_i[owner];
        bus_if.bus_hwdata_o = bus_if.m_hwdata_i[downer];
        if (bus_if.m_hsel_i[owner]) begin
            bus_if.bus_htrans_o    = bus_if.m_htrans_i[owner];
            bus_if.bus_hmastlock_o = bus_if.m_hmastlock_i[owner];
        end else begin
            bus_if.bus_htrans_o    = HTRANS_IDLE;
            bus_if.bus_hmastlock_o = 1'b0;
        end
    end

    always_comb begin
        bus_if.m_hrdata_o = '0;
        bus_if.m_hready_o = '1;
        bus_if.m_hresp_o  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            bus_if.m_hrdata_o[i] = bus_if.bus_hrdata_i;
            if (owner == idx_t'(i) || (dvalid && downer == idx_t'(i))) begin
                bus_if.m_hready_o[i] = bus_if.bus_hready_i;
            end else begin
                bus_if.m_hready_o[i] = ~req[i];
            end
            if (dvalid && downer == idx_t'(i)) begin
                bus_if.m_hresp_o[i] = bus_if.bus_hresp_i;
            end
        end
    end

    // INCR bursts load a zero count, so a SEQ beat of an INCR burst always holds.
    always_comb begin
        hold = 1'b0;
        if (bus_if.m_hmastlock_i[owner]) begin
            hold = 1'b1;
        end else begin
            case (bus_if.bus_htrans_o)
                HTRANS_BUSY:   hold = 1'b1;
                HTRANS_SEQ:    hold = (beat_cnt != 5'd1) ||
                                      (bus_if.bus_hburst_o == HBURST_INCR);
                HTRANS_NONSEQ: hold = (bus_if.bus_hburst_o != HBURST_SINGLE);
                default:       hold = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (bus_if.bus_hburst_o)
            3'b010, 3'b011: beat_load = 5'd3;
            3'b100, 3'b101: beat_load = 5'd7;
            3'b110, 3'b111: beat_load = 5'd15;
            default:        beat_load = 5'd0;
        endcase
    end

    // Scan starts just after the last winner, so the current owner is considered last.
    always_comb begin
        winner = owner;
        found  = 1'b0;
        cand   = last;
        for (int k = 0; k < MASTERS; k++) begin
            cand = (cand == idx_t'(MASTERS - 1)) ? '0 : cand + idx_t'(1);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner    <= '0;
            last     <= idx_t'(MASTERS - 1);
            downer   <= '0;
            dvalid   <= 1'b0;
            beat_cnt <= '0;
        end else if (bus_if.bus_hready_i) begin
            downer <= owner;
            dvalid <= bus_if.bus_htrans_o[1];
            if (bus_if.bus_htrans_o == HTRANS_NONSEQ) begin
                beat_cnt <= beat_load;
            end else if (bus_if.bus_htrans_o == HTRANS_SEQ && beat_cnt != 5'd0) begin
                beat_cnt <= beat_cnt - 5'd1;
            end
            if (!hold && found) begin
                owner <= winner;
                last  <= winner;
            end
        end
    end
endmodule

// File: tb/tb_ahb3_arbiter.sv
// Directed bench for ahb3_arbiter: a behavioural ownership model is checked every
// cycle, and literal expectations pin the key scenarios.
module tb_ahb3_arbiter;
    localparam int MASTERS = 2;
    localparam int XLEN    = 32;
    localparam int PLEN    = 32;
    localparam int SW      = XLEN >> 3;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ahb3_arbiter_if #(.MASTERS(MASTERS), .XLEN(XLEN), .PLEN(PLEN)) bus ();

    ahb3_arbiter #(.MASTERS(MASTERS), .XLEN(XLEN), .PLEN(PLEN)) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: who owns the address phase, who owns the data phase.
    int mo_owner;
    int mo_last;
    int mo_downer;
    int mo_left;
    bit mo_dvalid;

    function automatic bit mreq(input int i);
        return bus.m_hsel_i[i] && bus.m_htrans_i[i][1];
    endfunction

    function automatic logic [1:0] expTrans();
        return bus.m_hsel_i[mo_owner] ? bus.m_htrans_i[mo_owner] : IDLE;
    endfunction

    function automatic int burstLen(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    function automatic bit expHold();
        logic [1:0] t;
        logic [2:0] b;
        t = expTrans();
        b = bus.m_hburst_i[mo_owner];
        if (bus.m_hmastlock_i[mo_owner]) return 1'b1;
        if (t == 2'b01) return 1'b1;
        if (t == NONSEQ && b != SINGLE) return 1'b1;
        if (t == SEQ && (b == 3'b001 || mo_left != 1)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mo_owner  = 0;
            mo_last   = MASTERS - 1;
            mo_downer = 0;
            mo_dvalid = 1'b0;
            mo_left   = 0;
        end else if (bus.bus_hready_i) begin
            logic [1:0] t;
            bit         h;
            int         nxt;
            t   = expTrans();
            h   = expHold();
            nxt = -1;
            for (int k = 1; k <= MASTERS; k++) begin
                if (nxt < 0 && mreq((mo_last + k) % MASTERS)) nxt = (mo_last + k) % MASTERS;
            end
            if (t == NONSEQ) mo_left = burstLen(bus.m_hburst_i[mo_owner]) - 1;
            else if (t == SEQ && mo_left > 0) mo_left = mo_left - 1;
            mo_downer = mo_owner;
            mo_dvalid = t[1];
            if (!h && nxt >= 0) begin
                mo_owner = nxt;
                mo_last  = nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [MASTERS-1:0] exp_ready;
            logic [MASTERS-1:0] exp_resp;
            for (int i = 0; i < MASTERS; i++) begin
                if (i == mo_owner || (mo_dvalid && i == mo_downer)) exp_ready[i] = bus.bus_hready_i;
                else exp_ready[i] = !mreq(i);
                exp_resp[i] = (mo_dvalid && i == mo_downer) ? bus.bus_hresp_i : 1'b0;
            end
            checkOutput("model_hsel",   bus.bus_hsel_o,   bus.m_hsel_i[mo_owner]);
            checkOutput("model_haddr",  bus.bus_haddr_o,  bus.m_haddr_i[mo_owner]);
            checkOutput("model_hwrite", bus.bus_hwrite_o, bus.m_hwrite_i[mo_owner]);
            checkOutput("model_hsize",  bus.bus_hsize_o,  bus.m_hsize_i[mo_owner]);
            checkOutput("model_hburst", bus.bus_hburst_o, bus.m_hburst_i[mo_owner]);
            checkOutput("model_hprot",  bus.bus_hprot_o,  bus.m_hprot_i[mo_owner]);
            checkOutput("model_htrans", bus.bus_htrans_o, expTrans());
            checkOutput("model_hmastlock", bus.bus_hmastlock_o,
                        bus.m_hsel_i[mo_owner] ? bus.m_hmastlock_i[mo_owner] : 1'b0);
            checkOutput("model_hwdata", bus.bus_hwdata_o, bus.m_hwdata_i[mo_downer]);
            checkOutput("model_m_hready", bus.m_hready_o, exp_ready);
            checkOutput("model_m_hresp",  bus.m_hresp_o,  exp_resp);
            checkOutput("model_m_hrdata", bus.m_hrdata_o, {bus.bus_hrdata_i, bus.bus_hrdata_i});
        end
    end

    task automatic applyStimulus(input int m, input logic sel, input logic [1:0] trans,
                                 input logic [PLEN-1:0] addr, input logic wr,
                                 input logic [2:0] burst, input logic lock,
                                 input logic [XLEN-1:0] wdata);
        bus.m_hsel_i[m]      = sel;
        bus.m_htrans_i[m]    = trans;
        bus.m_haddr_i[m]     = addr;
        bus.m_hwrite_i[m]    = wr;
        bus.m_hburst_i[m]    = burst;
        bus.m_hmastlock_i[m] = lock;
        bus.m_hwdata_i[m]    = wdata;
        bus.m_hsize_i[m]     = 3'b010;
        bus.m_hprot_i[m]     = SW'(3);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atSample();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int m = 0; m < MASTERS; m++) applyStimulus(m, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        bus.bus_hready_i = 1'b1;
        bus.bus_hresp_i  = 1'b0;
        bus.bus_hrdata_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt0;
        int cnt1;
        doReset();

        // Reset state
        atSample();
        checkOutput("rst_htrans", bus.bus_htrans_o, IDLE);
        checkOutput("rst_hsel",   bus.bus_hsel_o,   1'b0);
        checkOutput("rst_hready", bus.m_hready_o,   2'b11);
        checkOutput("rst_hresp",  bus.m_hresp_o,    2'b00);

        // Single requester M1
        nextCycle();
        applyStimulus(1, 1'b1, NONSEQ, 32'h8000_0000, 1'b0, SINGLE, 1'b0, '0);
        atSample();
        checkOutput("single_stall", bus.m_hready_o[1], 1'b0);
        checkOutput("single_idle",  bus.bus_htrans_o,  IDLE);
        nextCycle();
        atSample();
        checkOutput("single_addr",   bus.bus_haddr_o,  32'h8000_0000);
        checkOutput("single_trans",  bus.bus_htrans_o, NONSEQ);
        checkOutput("single_ready",  bus.m_hready_o[1], 1'b1);
        nextCycle();
        applyStimulus(1, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        bus.bus_hrdata_i = 32'hDEAD_BEEF;
        bus.bus_hready_i = 1'b0;
        atSample();
        checkOutput("single_wait_ready", bus.m_hready_o[1], 1'b0);
        checkOutput("single_rdata",      bus.m_hrdata_o[1], 32'hDEAD_BEEF);
        nextCycle();
        bus.bus_hready_i = 1'b1;
        atSample();
        checkOutput("single_done_ready", bus.m_hready_o[1], 1'b1);
        checkOutput("single_done_rdata", bus.m_hrdata_o[1], 32'hDEAD_BEEF);
        nextCycle();
        bus.bus_hrdata_i = '0;

        // Round robin: owner starts at M1, so grants go 1,0,1,0...
        applyStimulus(0, 1'b1, NONSEQ, 32'h0000_1000, 1'b0, SINGLE, 1'b0, '0);
        applyStimulus(1, 1'b1, NONSEQ, 32'h0000_2000, 1'b0, SINGLE, 1'b0, '0);
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 20; k++) begin
            atSample();
            checkOutput("rr_grant", bus.bus_haddr_o, (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
            if (bus.bus_haddr_o == 32'h0000_1000) cnt0++;
            if (bus.bus_haddr_o == 32'h0000_2000) cnt1++;
            nextCycle();
        end
        checkOutput("rr_m0_count", cnt0, 10);
        checkOutput("rr_m1_count", cnt1, 10);

        // INCR4 write from M0 with M1 waiting from beat 2
        doReset();
        applyStimulus(0, 1'b1, NONSEQ, 32'h0000_0050, 1'b0, SINGLE, 1'b0, '0);
        atSample();
        checkOutput("burst_pre_addr", bus.bus_haddr_o, 32'h0000_0050);
        nextCycle();
        applyStimulus(0, 1'b1, NONSEQ, 32'h0000_0100, 1'b1, INCR4, 1'b0, '0);
        atSample();
        checkOutput("burst_b1_trans", bus.bus_htrans_o, NONSEQ);
        nextCycle();
        applyStimulus(0, 1'b1, SEQ, 32'h0000_0104, 1'b1, INCR4, 1'b0, 32'hA0A0_0000);
        applyStimulus(1, 1'b1, NONSEQ, 32'h0000_2000, 1'b0, SINGLE, 1'b0, '0);
        atSample();
        checkOutput("burst_b2_addr",  bus.bus_haddr_o,  32'h0000_0104);
        checkOutput("burst_b2_wdata", bus.bus_hwdata_o, 32'hA0A0_0000);
        checkOutput("burst_b2_m1",    bus.m_hready_o[1], 1'b0);
        nextCycle();
        applyStimulus(0, 1'b1, SEQ, 32'h0000_0108, 1'b1, INCR4, 1'b0, 32'hA0A0_0001);
        atSample();
        checkOutput("burst_b3_addr", bus.bus_haddr_o, 32'h0000_0108);
        checkOutput("burst_b3_m1",   bus.m_hready_o[1], 1'b0);
        nextCycle();
        applyStimulus(0, 1'b1, SEQ, 32'h0000_010C, 1'b1, INCR4, 1'b0, 32'hA0A0_0002);
        atSample();
        checkOutput("burst_b4_addr", bus.bus_haddr_o, 32'h0000_010C);
        checkOutput("burst_b4_m1",   bus.m_hready_o[1], 1'b0);
        nextCycle();
        applyStimulus(0, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, 32'hA0A0_0003);
        atSample();
        checkOutput("burst_m1_addr",   bus.bus_haddr_o,  32'h0000_2000);
        checkOutput("burst_last_wdata", bus.bus_hwdata_o, 32'hA0A0_0003);
        checkOutput("burst_m1_ready",  bus.m_hready_o[1], 1'b1);
        nextCycle();
        applyStimulus(0, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        applyStimulus(1, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        nextCycle();

        // Locked sequence from M1 with two wait states
        applyStimulus(1, 1'b1, NONSEQ, 32'h0000_0300, 1'b0, SINGLE, 1'b1, '0);
        applyStimulus(0, 1'b1, NONSEQ, 32'h0000_0400, 1'b0, SINGLE, 1'b0, '0);
        atSample();
        checkOutput("lock_addr0", bus.bus_haddr_o, 32'h0000_0300);
        checkOutput("lock_mlock", bus.bus_hmastlock_o, 1'b1);
        checkOutput("lock_m0_stall0", bus.m_hready_o[0], 1'b0);
        nextCycle();
        applyStimulus(1, 1'b1, NONSEQ, 32'h0000_0304, 1'b0, SINGLE, 1'b1, '0);
        bus.bus_hready_i = 1'b0;
        atSample();
        checkOutput("lock_wait1_addr", bus.bus_haddr_o, 32'h0000_0304);
        checkOutput("lock_wait1_ready", bus.m_hready_o, 2'b00);
        nextCycle();
        atSample();
        checkOutput("lock_wait2_addr",  bus.bus_haddr_o, 32'h0000_0304);
        checkOutput("lock_wait2_ready", bus.m_hready_o, 2'b00);
        nextCycle();
        bus.bus_hready_i = 1'b1;
        atSample();
        checkOutput("lock_resume_addr", bus.bus_haddr_o, 32'h0000_0304);
        nextCycle();
        applyStimulus(1, 1'b1, NONSEQ, 32'h0000_0308, 1'b0, SINGLE, 1'b1, '0);
        atSample();
        checkOutput("lock_addr2", bus.bus_haddr_o, 32'h0000_0308);
        checkOutput("lock_m0_stall2", bus.m_hready_o[0], 1'b0);
        nextCycle();
        applyStimulus(1, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        atSample();
        checkOutput("lock_drop_trans", bus.bus_htrans_o, IDLE);
        checkOutput("lock_drop_m0", bus.m_hready_o[0], 1'b0);
        nextCycle();
        atSample();
        checkOutput("lock_m0_addr",  bus.bus_haddr_o, 32'h0000_0400);
        checkOutput("lock_m0_ready", bus.m_hready_o[0], 1'b1);
        nextCycle();
        applyStimulus(0, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        nextCycle();

        // ERROR response on M0's data phase while M1 owns the address phase
        applyStimulus(0, 1'b1, NONSEQ, 32'h0000_0500, 1'b0, SINGLE, 1'b0, '0);
        applyStimulus(1, 1'b1, NONSEQ, 32'h0000_0600, 1'b0, SINGLE, 1'b0, '0);
        atSample();
        checkOutput("err_m0_addr", bus.bus_haddr_o, 32'h0000_0500);
        nextCycle();
        applyStimulus(0, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        bus.bus_hresp_i  = 1'b1;
        bus.bus_hready_i = 1'b0;
        atSample();
        checkOutput("err_m1_addr", bus.bus_haddr_o, 32'h0000_0600);
        checkOutput("err_resp1",   bus.m_hresp_o,   2'b01);
        checkOutput("err_m0_wait", bus.m_hready_o[0], 1'b0);
        nextCycle();
        bus.bus_hready_i = 1'b1;
        atSample();
        checkOutput("err_resp2", bus.m_hresp_o, 2'b01);
        nextCycle();
        bus.bus_hresp_i = 1'b0;
        applyStimulus(1, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        atSample();
        checkOutput("err_clear", bus.m_hresp_o, 2'b00);
        nextCycle();

        // Reset in the middle of an M1 burst
        applyStimulus(1, 1'b1, NONSEQ, 32'h0000_0700, 1'b0, INCR4, 1'b0, '0);
        atSample();
        checkOutput("mid_addr", bus.bus_haddr_o, 32'h0000_0700);
        nextCycle();
        applyStimulus(1, 1'b1, SEQ, 32'h0000_0704, 1'b0, INCR4, 1'b0, '0);
        bus.bus_hresp_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_trans", bus.bus_htrans_o, IDLE);
        checkOutput("mid_rst_ready", bus.m_hready_o, 2'b01);
        checkOutput("mid_rst_resp",  bus.m_hresp_o,  2'b00);
        bus.bus_hresp_i = 1'b0;
        applyStimulus(1, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        atSample();
        checkOutput("post_rst_ready", bus.m_hready_o, 2'b11);
        nextCycle();
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
